iter_mul: RTL
=============

# iter_mul

Parametrised iterative multiplier for the multi-cycle ARM core. It replaces the single-cycle multiply path with a start/done unit that executes MUL, UMULL and SMULL over several clock cycles. It sits beside the ALU in the datapath and is sequenced by the controller, which holds the instruction FSM until `done`. Width and bits-per-iteration are generic, and accumulate forms are optional.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*WIDTH.
- `BPC`, default 1: multiplier bits consumed per iteration. Must divide WIDTH and be 1, 2 or 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation; sampled only when `busy`=0.
- `op`  in  2  operation select: MUL, UMULL or SMULL.
- `acc_en`  in  1  accumulate request (MLA/UMLAL/SMLAL); used only with MUL_ACCUM_EN.
- `a`, `b`  in  WIDTH  operands, Rm and Rs.
- `acc`  in  2*WIDTH  accumulate value; MUL uses only the low WIDTH bits.
- `busy`  out  1  high in RUN and FIX.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `result_lo`  out  WIDTH  product bits [WIDTH-1:0].
- `result_hi`  out  WIDTH  product bits [2*WIDTH-1:WIDTH]; always 0 for MUL.
- `nz`  out  2  {N,Z} flags of the result. C and V are not produced; the controller leaves them unchanged.

## Operation
- FSM states: IDLE, RUN, FIX, DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - Latch `op`, `acc_en` and `acc`.
  - For SMULL, latch |a| and |b| and record sign = a[MSB]^b[MSB]. Otherwise latch a and b unchanged.
  - Clear the 2*WIDTH partial product and the iteration counter. Go to RUN.
- RUN: each cycle, add (multiplicand << shift) * BPC-bit multiplier slice to the partial product. The counter increments each cycle. After N = WIDTH/BPC cycles, go to FIX.
- FIX:
  - Two's-complement negate the product if the SMULL sign is set.
  - Then add `acc` if accumulate is active. The sum is modulo 2^(2*WIDTH) for long ops and modulo 2^WIDTH for MUL.
  - Register `result_lo`, `result_hi` and `nz`. Go to DONE.
- DONE: `done`=1 for this cycle only. Next state is RUN if `start`=1 (back-to-back), otherwise IDLE.
- op encoding 2'b11 is reserved and executes as MUL.
- Flags:
  - MUL: N = result_lo[MSB], Z = (result_lo == 0).
  - Long ops: N = result_hi[MSB], Z = (full 2*WIDTH result == 0).
- `start` while `busy`=1 is ignored and has no side effects.
- SMULL with the most negative operand: the magnitude is 2^(WIDTH-1), which is representable unsigned, so the result is exact.
- Reset mid-operation: the FSM returns to IDLE immediately and the operation is abandoned. No `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `nz`=2'b01.
- Latency from the `start` edge to `done`: N+2 cycles (1 load, N RUN, 1 FIX). With the defaults this is 34 cycles.
- `busy` rises the cycle after `start` is accepted and falls in the DONE cycle.
- `result_*` and `nz` change only on the FIX→DONE edge. They hold their value through later operations until the next FIX.
- Throughput: one result every N+2 cycles with back-to-back `start`.
- Operands are sampled only at acceptance; `a`, `b` and `acc` may change freely afterwards.

## Configuration
- `ITER_MUL_ACCUM_EN` defined:
  - `acc_en`=1 adds `acc` in FIX (MLA, UMLAL, SMLAL).
- Not defined:
  - The accumulate adder and acc register are not built.
  - `acc_en` and `acc` are ignored and the result is the pure product.
  - Ports remain present so the top-level wiring is identical in both builds.

## Structure
- Package `iter_mul_pkg` holds:
  - op encodings: OP_MUL=2'b00, OP_UMULL=2'b01, OP_SMULL=2'b10, OP_RSV=2'b11;
  - the FSM state encoding;
  - a helper that computes N from WIDTH and BPC.
- Sub-module `iter_mul_step`: combinational BPC-bit shift-add step taking the partial product, multiplicand, multiplier slice and shift. It is instantiated once in RUN.
- The top module owns the FSM, counter, operand registers, FIX logic and output registers.

## Test plan
All scenarios use WIDTH=32, BPC=1 unless stated otherwise.
- MUL 7×6: `done` arrives 34 cycles after `start`; result_lo=42, result_hi=0, nz=00.
- UMULL 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, N=1.
- SMULL −2×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, N=1. SMULL 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- MUL 0×0x1234 → result 0, nz=01. A second `start` pulsed at cycle 10 of the run is ignored: exactly one `done`.
- Reset asserted at cycle 15 of a run → `busy`=0 and outputs return to their reset values. No `done` appears. A new MUL 3×5 then returns 15.
- With `ITER_MUL_ACCUM_EN` and `acc_en`=1:
  - MLA 7×6+100 → 142.
  - UMLAL 0xFFFFFFFF×2 + 64'h1 → hi=1, lo=0xFFFFFFFF.
  - Repeat the full suite with BPC=4: latency 10 cycles, identical results.

Source files
------------

// File: rtl/iter_mul_pkg.sv
// Shared definitions for the iterative multiplier: op encodings, FSM states
// and the iteration-count helper.
package iter_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_RSV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic int unsigned num_iter(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/iter_mul_step.sv
// Combinational shift-add step: adds (multiplicand * BPC-bit slice) << shift
// to the 2*WIDTH partial product.
module iter_mul_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic [2*WIDTH-1:0]         pp,
  input  logic [WIDTH-1:0]           mcand,
  input  logic [BPC-1:0]             slice,
  input  logic [$clog2(WIDTH)-1:0]   shift,
  output logic [2*WIDTH-1:0]         pp_next
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] part;

  always_comb begin
    part    = PW'(mcand) * PW'(slice);
    pp_next = pp + (part << shift);
  end

endmodule

// File: rtl/iter_mul.sv
// Iterative start/done multiplier for MUL, UMULL and SMULL.
// Accumulate forms (MLA/UMLAL/SMLAL) are built only when ITER_MUL_ACCUM_EN is defined.
module iter_mul
  import iter_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   acc,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result_lo,
  output logic [WIDTH-1:0]     result_hi,
  output logic [1:0]           nz
);

  localparam int unsigned N  = num_iter(WIDTH, BPC);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = $clog2(WIDTH);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [1:0]         op_r;
  logic               sign_r;
  logic [2*WIDTH-1:0] pp, pp_nx;
  logic [SW-1:0]      shift;
  logic               accept, is_smull, is_long;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_s, sum;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic [1:0]         fix_nz;

`ifdef ITER_MUL_ACCUM_EN
  logic               acc_en_r;
  logic [2*WIDTH-1:0] acc_r;
`else
  logic               unused_acc;
  assign unused_acc = ^{acc_en, acc};
`endif

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign is_smull = (op == OP_SMULL);
  // Magnitudes of the most negative operand wrap to 2^(WIDTH-1), which is the correct unsigned value.
  assign a_mag    = (is_smull && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign b_mag    = (is_smull && b[WIDTH-1]) ? WIDTH'(-b) : b;
  assign shift    = SW'(cnt * BPC);
  assign busy     = (state == ST_RUN) || (state == ST_FIX);
  assign done     = (state == ST_DONE);

  iter_mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .pp      (pp),
    .mcand   (mcand),
    .slice   (mplier[BPC-1:0]),
    .shift   (shift),
    .pp_next (pp_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == CW'(N - 1)) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Low WIDTH bits of a full-width sum equal the mod-2^WIDTH sum, so MUL shares the long adder.
  always_comb begin
    is_long = (op_r == OP_UMULL) || (op_r == OP_SMULL);
    prod_s  = sign_r ? (2*WIDTH)'(-pp) : pp;
`ifdef ITER_MUL_ACCUM_EN
    sum     = acc_en_r ? prod_s + acc_r : prod_s;
`else
    sum     = prod_s;
`endif
    fix_lo  = sum[WIDTH-1:0];
    fix_hi  = is_long ? sum[2*WIDTH-1:WIDTH] : '0;
    fix_nz  = is_long ? {sum[2*WIDTH-1], sum == '0}
                      : {sum[WIDTH-1], sum[WIDTH-1:0] == '0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      op_r      <= '0;
      sign_r    <= 1'b0;
      pp        <= '0;
      result_lo <= '0;
      result_hi <= '0;
      nz        <= 2'b01;
`ifdef ITER_MUL_ACCUM_EN
      acc_en_r  <= 1'b0;
      acc_r     <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r     <= op;
        sign_r   <= is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
        mcand    <= a_mag;
        mplier   <= b_mag;
        pp       <= '0;
        cnt      <= '0;
`ifdef ITER_MUL_ACCUM_EN
        acc_en_r <= acc_en;
        acc_r    <= acc;
`endif
      end else if (state == ST_RUN) begin
        pp     <= pp_nx;
        mplier <= mplier >> BPC;
        cnt    <= cnt + CW'(1);
      end
      if (state == ST_FIX) begin
        result_lo <= fix_lo;
        result_hi <= fix_hi;
        nz        <= fix_nz;
      end
    end
  end

endmodule
